// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a UART byte stream (MSB first) into instructions written to
// sequential instruction-memory addresses. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module instr_mem_loader #(
    parameter int unsigned           ADDR_WIDTH = 6,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_chk_err
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned SH_WIDTH  = DATA_WIDTH - 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [SH_WIDTH-1:0]   shreg_q, shreg_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
    logic                  chk_err_q, chk_err_d;
    logic [7:0]            xor_q, xor_d;
`endif

    // Next-state and next-output logic; every register output is computed here.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
`ifdef LOADER_CHECKSUM_EN
        chk_err_d  = chk_err_q;
        xor_d      = xor_q;
`endif
        // The word being written this cycle ends the load: HALT or the top address.
        last_word  = wr_en_q && ((wr_data_q == HALT_WORD) || (wr_addr_q == LAST_ADDR));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d    = S_RECV;
                    byte_idx_d = 2'd0;
                    wr_addr_d  = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    chk_err_d  = 1'b0;
                    xor_d      = '0;
`endif
                end
            end
            S_RECV: begin
                if (wr_en_q) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    if (wr_addr_q != LAST_ADDR) begin
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    end
                end
                if (last_word) begin
                    ovf_d = (wr_data_q != HALT_WORD);
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else if (i_rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ i_rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {shreg_q, i_rx_data};
                    end else begin
                        shreg_d = {shreg_q[SH_WIDTH-9:0], i_rx_data};
                    end
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (i_rx_valid) begin
                    chk_err_d = (i_rx_data != xor_q);
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RECV) || (state_d == S_CHK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_err_q  <= 1'b0;
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
            chk_err_q  <= chk_err_d;
            xor_q      <= xor_d;
`endif
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overflow   = ovf_q;
    assign o_word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign o_chk_err    = chk_err_q;
`else
    assign o_chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: vector table, hand-written corner sequences,
// and random loads checked against a word-list reference model.
module tb_instr_mem_loader;

    localparam int unsigned AW   = 6;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic [AW:0]   o_word_count;
    logic          o_chk_err;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wq_a[$];
    logic [31:0]   wq_d[$];
    logic [7:0]    stim[$];
    logic [31:0]   exp_d[$];
    logic          exp_ovf;
    logic [7:0]    exp_xor;

    typedef struct {
        int          nb;
        logic [95:0] b;
        int          gap;
        logic [7:0]  chk;
        int          nw;
        logic [95:0] w;
        logic        err;
    } vec_t;
    vec_t vecs[4];

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count),
        .o_chk_err    (o_chk_err)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_wr_en) begin
            wq_a.push_back(o_wr_addr);
            wq_d.push_back(o_wr_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: group the stream into MSB-first words, stop at HALT or a full memory.
    task automatic run_model();
        logic [31:0] w;
        exp_d.delete();
        exp_ovf = 1'b0;
        exp_xor = 8'h00;
        for (int i = 0; i + 3 < stim.size(); i += 4) begin
            w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
            exp_xor = exp_xor ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
            exp_d.push_back(w);
            if (w == HALT) break;
            if (exp_d.size() == (1 << AW)) begin
                exp_ovf = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_stim(input int gapmax, input bit bad_chk, input string tag);
        int         base;
        logic [7:0] c;
        run_model();
        base = wq_d.size();
        pulse_start();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (i != stim.size() - 1) repeat ($urandom_range(0, gapmax)) tick();
        end
        tick();
        tick();
        c = bad_chk ? (exp_xor ^ 8'h5A) : exp_xor;
        send_byte(c);
        for (int k = 0; k < 5 && o_done !== 1'b1; k++) tick();
        check({tag, " done"}, 32'(o_done), 32'd1);
        check({tag, " busy"}, 32'(o_busy), 32'd0);
        check({tag, " count"}, 32'(o_word_count), 32'(exp_d.size()));
        check({tag, " overflow"}, 32'(o_overflow), 32'(exp_ovf));
        check({tag, " chk_err"}, 32'(o_chk_err), 32'(CHK_EN && bad_chk));
        check({tag, " nwrites"}, 32'(wq_d.size() - base), 32'(exp_d.size()));
        for (int k = 0; k < exp_d.size() && base + k < wq_d.size(); k++) begin
            check({tag, " addr"}, 32'(wq_a[base+k]), 32'(k));
            check({tag, " data"}, wq_d[base+k], exp_d[k]);
        end
        base = wq_d.size();
        send_byte(8'hA5);
        tick();
        tick();
        check({tag, " no write after done"}, 32'(wq_d.size() - base), 32'd0);
    endtask

    initial begin
        int          base;
        int          n;
        bit          halt;
        logic [31:0] w;

        rst        = 1'b1;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;

        vecs[0] = '{nb: 8,  b: 96'h20010005_FFFFFFFF_00000000, gap: 1, chk: 8'h24,
                    nw: 2, w: 96'h20010005_FFFFFFFF_00000000, err: 1'b0};
        vecs[1] = '{nb: 12, b: 96'h8C220004_AC230008_FFFFFFFF, gap: 0, chk: 8'h2D,
                    nw: 3, w: 96'h8C220004_AC230008_FFFFFFFF, err: 1'b0};
        vecs[2] = '{nb: 8,  b: 96'h01020304_FFFFFFFF_00000000, gap: 0, chk: 8'h04,
                    nw: 2, w: 96'h01020304_FFFFFFFF_00000000, err: 1'b0};
        vecs[3] = '{nb: 8,  b: 96'h01020304_FFFFFFFF_00000000, gap: 2, chk: 8'h05,
                    nw: 2, w: 96'h01020304_FFFFFFFF_00000000, err: CHK_EN};

        // Reset state and idle byte rejection.
        repeat (3) tick();
        check("rst wr_en", 32'(o_wr_en), 32'd0);
        check("rst addr", 32'(o_wr_addr), 32'd0);
        check("rst data", o_wr_data, 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check("rst overflow", 32'(o_overflow), 32'd0);
        check("rst count", 32'(o_word_count), 32'd0);
        check("rst chk_err", 32'(o_chk_err), 32'd0);
        rst = 1'b0;
        tick();
        send_byte(8'h11);
        tick();
        check("idle byte no write", 32'(wq_d.size()), 32'd0);
        check("idle busy", 32'(o_busy), 32'd0);

        // Vector table.
        for (int v = 0; v < 4; v++) begin
            base = wq_d.size();
            pulse_start();
            check($sformatf("vec%0d busy", v), 32'(o_busy), 32'd1);
            for (int i = 0; i < vecs[v].nb; i++) begin
                send_byte(vecs[v].b[95-8*i -: 8]);
                if (i < vecs[v].nb - 1) repeat (vecs[v].gap) tick();
            end
            check($sformatf("vec%0d halt wr_en", v), 32'(o_wr_en), 32'd1);
            check($sformatf("vec%0d halt data", v), o_wr_data, HALT);
            tick();
            check($sformatf("vec%0d wr_en drop", v), 32'(o_wr_en), 32'd0);
            check($sformatf("vec%0d early done", v), 32'(o_done), 32'(!CHK_EN));
            check($sformatf("vec%0d early busy", v), 32'(o_busy), 32'(CHK_EN));
            send_byte(vecs[v].chk);
            check($sformatf("vec%0d done", v), 32'(o_done), 32'd1);
            check($sformatf("vec%0d busy", v), 32'(o_busy), 32'd0);
            check($sformatf("vec%0d chk_err", v), 32'(o_chk_err), 32'(vecs[v].err));
            check($sformatf("vec%0d count", v), 32'(o_word_count), 32'(vecs[v].nw));
            check($sformatf("vec%0d overflow", v), 32'(o_overflow), 32'd0);
            check($sformatf("vec%0d nwrites", v), 32'(wq_d.size() - base), 32'(vecs[v].nw));
            for (int k = 0; k < vecs[v].nw && base + k < wq_d.size(); k++) begin
                check($sformatf("vec%0d addr%0d", v, k), 32'(wq_a[base+k]), 32'(k));
                check($sformatf("vec%0d data%0d", v, k), wq_d[base+k], vecs[v].w[95-32*k -: 32]);
            end
        end

        // Reset mid-word discards the partial word.
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        base = wq_d.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst done", 32'(o_done), 32'd0);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        tick();
        check("midrst nwrites", 32'(wq_d.size() - base), 32'd1);
        if (wq_d.size() > base) begin
            check("midrst addr", 32'(wq_a[base]), 32'd0);
            check("midrst data", wq_d[base], 32'h00000001);
        end
        check("midrst count", 32'(o_word_count), 32'd1);
        check("midrst next addr", 32'(o_wr_addr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Full memory without HALT.
        stim.delete();
        for (int k = 0; k < (1 << AW); k++) begin
            w = 32'(k);
            for (int j = 3; j >= 0; j--) stim.push_back(w[8*j +: 8]);
        end
        run_stim(0, 1'b0, "ovf");
        check("ovf flag", 32'(o_overflow), 32'd1);
        check("ovf count", 32'(o_word_count), 32'd64);

        // Random loads against the reference model.
        for (int r = 0; r < 8; r++) begin
            stim.delete();
            n    = $urandom_range(1, 1 << AW);
            halt = (n < (1 << AW)) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
                if (k == n - 1 && halt) w = HALT;
                for (int j = 3; j >= 0; j--) stim.push_back(w[8*j +: 8]);
            end
            run_stim(2, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
